// File: rtl/button_pkg.sv
// Shared types and constants for the button conditioner.
// Optional long-press detection is enabled by BUTTON_CONDITIONER_LONG_PRESS_EN.
package button_pkg;

    // Number of independent button channels.
    localparam int NUM_BUTTONS = 2;

    // Defaults sized for a 12 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;   // 10 ms
    localparam int DEFAULT_LONG_CYCLES     = 12000000; // 1 s

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_CHK_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_CHK_RELEASE = 2'd3
    } chan_state_e;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw switch inputs and their conditioned outputs.
// btn_long is only active when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.
interface button_conditioner_if;
    import button_pkg::*;

    logic [NUM_BUTTONS-1:0] btn_n;       // raw, asynchronous, active-low
    logic [NUM_BUTTONS-1:0] btn_level;   // debounced, active-high
    logic [NUM_BUTTONS-1:0] btn_press;   // one-cycle pulse on press
    logic [NUM_BUTTONS-1:0] btn_release; // one-cycle pulse on release
    logic [NUM_BUTTONS-1:0] btn_long;    // one-cycle pulse on long press

    // Board / stimulus side: drives the raw buttons, consumes the events.
    modport master (
        output btn_n,
        input  btn_level, btn_press, btn_release, btn_long
    );

    // Conditioner side.
    modport slave (
        input  btn_n,
        output btn_level, btn_press, btn_release, btn_long
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, four-state debounce FSM,
// registered level/press/release outputs and an optional long-press pulse
// (present only when BUTTON_CONDITIONER_LONG_PRESS_EN is defined).
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int              CW       = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Counters below rely on at least two cycles of terminal count.
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
        $error("debounce_channel: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic [1:0]    sync_q;
    logic          pressed;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Two-flop synchronizer; reset value 1 means "released".
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

    assign pressed = ~sync_q[1];

    // Debounce state and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and output-event decode.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                cnt_d = '0;
                if (pressed) state_d = ST_CHK_PRESS;
            end
            ST_CHK_PRESS: begin
                if (!pressed) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                cnt_d = '0;
                if (!pressed) state_d = ST_CHK_RELEASE;
            end
            ST_CHK_RELEASE: begin
                if (pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so the level and its
        // pulse change on the same edge as the FSM.
        level_d   = (state_d == ST_HELD) || (state_d == ST_CHK_RELEASE);
        press_d   = (state_q == ST_CHK_PRESS)   && (state_d == ST_HELD);
        release_d = (state_q == ST_CHK_RELEASE) && (state_d == ST_RELEASED);
    end

    // Registered level and event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int            HW        = ctr_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // Hold counter runs only in HELD and saturates; fired blocks repeats
    // until the level drops, so a release bounce cannot re-trigger.
    always_comb begin
        hold_d  = '0;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q == ST_HELD) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = hold_q;
                if (!fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
        if ((state_q == ST_RELEASED) || (state_q == ST_CHK_PRESS)) begin
            fired_d = 1'b0;
        end
    end

    // Long-press counter, one-shot flag and pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Top level: NUM_BUTTONS independent debounce channels behind one interface.
// Long-press pulses are generated only when BUTTON_CONDITIONER_LONG_PRESS_EN
// is defined; otherwise btn_long is constant 0.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  btn_if
);

    logic [NUM_BUTTONS-1:0] level_w;
    logic [NUM_BUTTONS-1:0] press_w;
    logic [NUM_BUTTONS-1:0] release_w;
    logic [NUM_BUTTONS-1:0] long_w;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_n_i   (btn_if.btn_n[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i]),
            .long_o    (long_w[i])
        );
    end

    assign btn_if.btn_level   = level_w;
    assign btn_if.btn_press   = press_w;
    assign btn_if.btn_release = release_w;
    assign btn_if.btn_long    = long_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=8,
// LONG_CYCLES=32. Reference model: a button's level flips once the
// two-cycle-delayed input has disagreed with it for DEBOUNCE_CYCLES+1
// consecutive samples; a long press fires on the LONG_CYCLES-th consecutive
// settled-pressed cycle, once per press.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int LAT  = DEB + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    button_conditioner_if bif();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bif)
    );

    // ---------------- reference model ----------------
    logic [1:0] m_p1 = 2'b11, m_p2 = 2'b11;
    logic [1:0] m_level = 2'b00, m_press = 2'b00, m_release = 2'b00, m_long = 2'b00;
    logic [1:0] m_fired = 2'b00;
    int         m_run[2] = '{0, 0};
    int         m_streak[2] = '{0, 0};

    always @(posedge clk) begin
        if (rst) begin
            m_p1 = 2'b11; m_p2 = 2'b11;
            m_level = 2'b00; m_press = 2'b00; m_release = 2'b00; m_long = 2'b00;
            m_fired = 2'b00;
            m_run = '{0, 0}; m_streak = '{0, 0};
        end else begin
            for (int b = 0; b < 2; b++) begin
                logic s;
                logic settled;
                s = ~m_p2[b];
                settled = m_level[b] && (m_run[b] == 0);
                m_press[b] = 1'b0; m_release[b] = 1'b0; m_long[b] = 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
                if (settled) begin
                    m_streak[b]++;
                    if (m_streak[b] == LONG && !m_fired[b]) begin
                        m_long[b] = 1'b1;
                        m_fired[b] = 1'b1;
                    end
                end else begin
                    m_streak[b] = 0;
                end
                if (!m_level[b]) m_fired[b] = 1'b0;
`else
                if (settled) m_streak[b] = 0;
`endif
                if (s != m_level[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB + 1) begin
                        m_level[b] = s;
                        m_run[b] = 0;
                        if (s) m_press[b] = 1'b1;
                        else   m_release[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = bif.btn_n;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bif.btn_n = 2'b11;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long} !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b lng=%b want all 0",
                         c, bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        bif.btn_n = 2'b10;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long} !==
                {m_level, m_press, m_release, m_long}) begin
                failures++;
                $display("FAIL clean_press_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long,
                         m_level, m_press, m_release, m_long);
            end
            if (c == LAT) begin
                checks++;
                if (bif.btn_press !== 2'b01 || bif.btn_level !== 2'b01) begin
                    failures++;
                    $display("FAIL clean_press_edge cyc=%0d got prs=%b lvl=%b want prs=01 lvl=01",
                             c, bif.btn_press, bif.btn_level);
                end
            end else if (c < LAT) begin
                checks++;
                if (bif.btn_level !== 2'b00 || bif.btn_press !== 2'b00) begin
                    failures++;
                    $display("FAIL clean_press_early cyc=%0d got prs=%b lvl=%b want 00/00",
                             c, bif.btn_press, bif.btn_level);
                end
            end
        end
    endtask

    task automatic test_release();
        bif.btn_n = 2'b11;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_release}) begin
                failures++;
                $display("FAIL release_model cyc=%0d got %b/%b/%b want %b/%b/%b", c,
                         bif.btn_level, bif.btn_press, bif.btn_release, m_level, m_press, m_release);
            end
            if (c == LAT) begin
                checks++;
                if (bif.btn_release !== 2'b01 || bif.btn_level !== 2'b00) begin
                    failures++;
                    $display("FAIL release_edge cyc=%0d got rel=%b lvl=%b want rel=01 lvl=00",
                             c, bif.btn_release, bif.btn_level);
                end
            end else begin
                checks++;
                if (bif.btn_release !== 2'b00) begin
                    failures++;
                    $display("FAIL release_single cyc=%0d got rel=%b want 00", c, bif.btn_release);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 1; c <= 25; c++) begin
            bif.btn_n = (c <= 5) ? 2'b10 : 2'b11;
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
                failures++;
                $display("FAIL bounce_quiet cyc=%0d got lvl=%b prs=%b rel=%b want 0",
                         c, bif.btn_level, bif.btn_press, bif.btn_release);
            end
        end
    endtask

    task automatic test_reset_mid();
        bif.btn_n = 2'b10;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long} !== 8'h00) begin
                failures++;
                $display("FAIL reset_mid_outputs cyc=%0d got %b/%b/%b/%b want 0", c,
                         bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            checks++;
            if (bif.btn_press !== ((c == LAT) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL reset_mid_press cyc=%0d got prs=%b want %b", c,
                         bif.btn_press, (c == LAT) ? 2'b01 : 2'b00);
            end
        end
        bif.btn_n = 2'b11;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic test_long_press();
        int pulses = 0;
        int at = -1;
        bif.btn_n = 2'b10;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bif.btn_long !== 2'b00) begin
                pulses++;
                at = c;
            end
            checks++;
            if (bif.btn_long !== m_long) begin
                failures++;
                $display("FAIL long_model cyc=%0d got lng=%b want %b", c, bif.btn_long, m_long);
            end
        end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        checks++;
        if (pulses != 1 || at != LAT + LONG) begin
            failures++;
            $display("FAIL long_pulse got pulses=%0d at=%0d want pulses=1 at=%0d", pulses, at, LAT + LONG);
        end
`else
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL long_disabled got pulses=%0d at=%0d want 0", pulses, at);
        end
`endif
        bif.btn_n = 2'b11;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bif.btn_n = 2'b00;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == LAT) begin
                checks++;
                if (bif.btn_press !== 2'b11 || bif.btn_level !== 2'b11) begin
                    failures++;
                    $display("FAIL simul_press got prs=%b lvl=%b want 11/11", bif.btn_press, bif.btn_level);
                end
            end
        end
        bif.btn_n = 2'b11;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == LAT) begin
                checks++;
                if (bif.btn_release !== 2'b11 || bif.btn_level !== 2'b00) begin
                    failures++;
                    $display("FAIL simul_release got rel=%b lvl=%b want 11/00", bif.btn_release, bif.btn_level);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int         rem[2] = '{0, 0};
        logic [1:0] val = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    val[b] = 1'($urandom_range(0, 1));
                    rem[b] = $urandom_range(1, 6 * DEB);
                end
                rem[b]--;
            end
            bif.btn_n = val;
            rst = ($urandom_range(0, 799) == 0);
            @(negedge clk);
            checks++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long} !==
                {m_level, m_press, m_release, m_long}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c,
                         bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long,
                         m_level, m_press, m_release, m_long);
            end
        end
        rst = 1'b0;
        bif.btn_n = 2'b11;
        repeat (LAT + 4) @(negedge clk);
    endtask

    initial begin
        bif.btn_n = 2'b11;
        test_reset();
        test_clean_press();
        test_release();
        repeat (4) @(negedge clk);
        test_bounce();
        test_reset_mid();
        test_long_press();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
